// File: rtl/div32_iter.sv
// div32_iter: iterative signed divider, restoring, one quotient bit per cycle.
// Macro DIV_REMAINDER_EN adds a data_remainder output.
//
// Ports:
//   clock, reset        rising-edge clock, sync active-high reset
//   ctrl_DIV            start pulse; operands sampled on that edge
//   data_operandA/B     dividend / divisor, two's complement
//   data_result         quotient, truncated toward zero
//   data_exception      divide-by-zero or overflow
//   data_resultRDY      one-cycle pulse, result valid
//   busy                high while an operation is in flight
//   data_remainder      (DIV_REMAINDER_EN) remainder, sign of dividend
module div32_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   bmag;
  logic [WIDTH-1:0] q;
  logic             sign_q;
  logic             exc_q;
`ifdef DIV_REMAINDER_EN
  logic             sign_a;
`endif

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;
  logic             ovf;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH:0]   rem_nx;

  // -(0x80000000) wraps to itself, read as unsigned 2^31
  always_comb begin
    a_mag  = data_operandA[WIDTH-1] ? -data_operandA
                                    : data_operandA;
    b_mag  = data_operandB[WIDTH-1] ? -data_operandB
                                    : data_operandB;
    b_zero = (data_operandB == '0);
    ovf    = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
          && (&data_operandB);
  end

  always_comb begin
    rem_sh = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    ge     = (rem_sh >= bmag);
    rem_nx = ge ? (rem_sh - bmag) : rem_sh;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      dvd            <= '0;
      rem            <= '0;
      bmag           <= '0;
      q              <= '0;
      sign_q         <= 1'b0;
      exc_q          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
`ifdef DIV_REMAINDER_EN
      sign_a         <= 1'b0;
      data_remainder <= '0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ctrl_DIV) begin
            dvd    <= a_mag;
            bmag   <= {1'b0, b_mag};
            rem    <= '0;
            q      <= '0;
            cnt    <= '0;
            sign_q <= data_operandA[WIDTH-1]
                    ^ data_operandB[WIDTH-1];
            exc_q  <= b_zero | ovf;
`ifdef DIV_REMAINDER_EN
            sign_a <= data_operandA[WIDTH-1];
`endif
            // zero divisor skips the loop; q/rem stay 0
            if (b_zero) begin
              state <= DONE;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          rem <= rem_nx;
          dvd <= dvd << 1;
          q   <= {q[WIDTH-2:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          data_resultRDY <= 1'b1;
          data_result    <= sign_q ? -q : q;
          data_exception <= exc_q;
`ifdef DIV_REMAINDER_EN
          data_remainder <= sign_a ? -rem[WIDTH-1:0]
                                   : rem[WIDTH-1:0];
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
